// File: rtl/br_stack.sv
// Branch checkpoint stack: one entry per one-hot branch tag holding the pre-branch mask and free-list head.
// Latency: reads are combinational on rob_br_tag_i; writes/invalidates land on the next clk edge. No backpressure (caller gates on br_full_o).
// Optional checker: define BR_STACK_CHECK_EN to build the sticky br_err_o protocol monitor.
module br_stack #(
    parameter int BR_MASK_W = 4,
    parameter int FL_PTR_W  = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         dispatch_br_en_i,
    input  logic [BR_MASK_W-1:0]         dispatch_br_tag_i,
    input  logic [BR_MASK_W-1:0]         dispatch_br_mask_i,
    input  logic [FL_PTR_W-1:0]          fl_head_i,
    input  logic                         rob_br_pred_correct_i,
    input  logic                         rob_br_recovery_i,
    input  logic [BR_MASK_W-1:0]         rob_br_tag_i,
    output logic [BR_MASK_W-1:0]         br_recovery_mask_o,
    output logic [FL_PTR_W-1:0]          br_recovery_fl_head_o,
    output logic [BR_MASK_W-1:0]         br_valid_o,
    output logic [$clog2(BR_MASK_W):0]   br_cnt_o,
    output logic                         br_full_o,
    output logic                         br_err_o
);

    localparam int CW = $clog2(BR_MASK_W) + 1;

    logic [BR_MASK_W-1:0] valid_q, valid_d;
    logic [BR_MASK_W-1:0] mask_q [BR_MASK_W];
    logic [BR_MASK_W-1:0] mask_d [BR_MASK_W];
    logic [FL_PTR_W-1:0]  fl_q   [BR_MASK_W];
    logic [FL_PTR_W-1:0]  fl_d   [BR_MASK_W];
    logic [BR_MASK_W-1:0] clr;
    logic [CW-1:0]        cnt_q;

    function automatic logic [CW-1:0] popcnt(input logic [BR_MASK_W-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < BR_MASK_W; i++) c = c + CW'(v[i]);
        return c;
    endfunction

    // OR-select keeps the read deterministic even for a zero or invalid index
    always_comb begin
        br_recovery_mask_o    = '0;
        br_recovery_fl_head_o = '0;
        for (int i = 0; i < BR_MASK_W; i++) begin
            if (rob_br_tag_i[i]) begin
                br_recovery_mask_o    = br_recovery_mask_o | mask_q[i];
                br_recovery_fl_head_o = br_recovery_fl_head_o | fl_q[i];
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        mask_d  = mask_q;
        fl_d    = fl_q;
        clr     = rob_br_pred_correct_i ? rob_br_tag_i : '0;
        if (rob_br_recovery_i) begin
            // squash the mispredicted entry and every entry younger than it
            for (int i = 0; i < BR_MASK_W; i++) begin
                if (rob_br_tag_i[i] || (|(mask_q[i] & rob_br_tag_i))) valid_d[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < BR_MASK_W; i++) begin
                mask_d[i] = mask_q[i] & ~clr;
                if (clr[i]) valid_d[i] = 1'b0;
                // dispatch wins over a same-tag resolve; the resolved bit is forwarded out of its mask
                if (dispatch_br_en_i && dispatch_br_tag_i[i]) begin
                    valid_d[i] = 1'b1;
                    mask_d[i]  = dispatch_br_mask_i & ~clr;
                    fl_d[i]    = fl_head_i;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < BR_MASK_W; i++) begin
                mask_q[i] <= '0;
                fl_q[i]   <= '0;
            end
        end else begin
            valid_q <= valid_d;
            cnt_q   <= popcnt(valid_d);
            for (int i = 0; i < BR_MASK_W; i++) begin
                mask_q[i] <= mask_d[i];
                fl_q[i]   <= fl_d[i];
            end
        end
    end

    assign br_valid_o = valid_q;
    assign br_cnt_o   = cnt_q;
    assign br_full_o  = &valid_q;

`ifdef BR_STACK_CHECK_EN
    function automatic logic onehot(input logic [BR_MASK_W-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

    logic err_q, err_hit;

    always_comb begin
        err_hit = 1'b0;
        if (dispatch_br_en_i && !rob_br_recovery_i && (|(dispatch_br_tag_i & valid_q & ~clr)))
            err_hit = 1'b1;
        if ((rob_br_pred_correct_i || rob_br_recovery_i) && (|(rob_br_tag_i & ~valid_q)))
            err_hit = 1'b1;
        if (dispatch_br_en_i && !onehot(dispatch_br_tag_i))
            err_hit = 1'b1;
        if ((rob_br_pred_correct_i || rob_br_recovery_i) && !onehot(rob_br_tag_i))
            err_hit = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_q <= 1'b0;
        else      err_q <= err_q | err_hit;
    end

    assign br_err_o = err_q;
`else
    assign br_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_br_stack.sv
// Directed-vector bench for br_stack (BR_MASK_W=4, FL_PTR_W=5).
module tb_br_stack;

    logic       clk = 1'b0;
    logic       rst;
    logic       dispatch_br_en_i;
    logic [3:0] dispatch_br_tag_i;
    logic [3:0] dispatch_br_mask_i;
    logic [4:0] fl_head_i;
    logic       rob_br_pred_correct_i;
    logic       rob_br_recovery_i;
    logic [3:0] rob_br_tag_i;
    logic [3:0] br_recovery_mask_o;
    logic [4:0] br_recovery_fl_head_o;
    logic [3:0] br_valid_o;
    logic [2:0] br_cnt_o;
    logic       br_full_o;
    logic       br_err_o;

    int vectors = 0;
    int miscompares = 0;

    br_stack #(.BR_MASK_W(4), .FL_PTR_W(5)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .dispatch_br_en_i      (dispatch_br_en_i),
        .dispatch_br_tag_i     (dispatch_br_tag_i),
        .dispatch_br_mask_i    (dispatch_br_mask_i),
        .fl_head_i             (fl_head_i),
        .rob_br_pred_correct_i (rob_br_pred_correct_i),
        .rob_br_recovery_i     (rob_br_recovery_i),
        .rob_br_tag_i          (rob_br_tag_i),
        .br_recovery_mask_o    (br_recovery_mask_o),
        .br_recovery_fl_head_o (br_recovery_fl_head_o),
        .br_valid_o            (br_valid_o),
        .br_cnt_o              (br_cnt_o),
        .br_full_o             (br_full_o),
        .br_err_o              (br_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic idle();
        dispatch_br_en_i      = 1'b0;
        dispatch_br_tag_i     = '0;
        dispatch_br_mask_i    = '0;
        fl_head_i             = '0;
        rob_br_pred_correct_i = 1'b0;
        rob_br_recovery_i     = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic disp(input logic [3:0] tag, input logic [3:0] mask, input logic [4:0] fl);
        dispatch_br_en_i   = 1'b1;
        dispatch_br_tag_i  = tag;
        dispatch_br_mask_i = mask;
        fl_head_i          = fl;
        tick();
    endtask

    task automatic rd(input logic [3:0] tag);
        rob_br_tag_i = tag;
        #1;
    endtask

    initial begin
        rst = 1'b0;
        rob_br_tag_i = '0;
        idle();
        #12;
        chk("rst_valid", 32'(br_valid_o), 32'h0);
        chk("rst_cnt",   32'(br_cnt_o),   32'h0);
        chk("rst_full",  32'(br_full_o),  32'h0);
        chk("rst_err",   32'(br_err_o),   32'h0);
        rst = 1'b1;
        @(posedge clk); #1;

        // single dispatch, readback of fl_head
        disp(4'b0001, 4'b0000, 5'd3);
        chk("d1_valid", 32'(br_valid_o), 32'h1);
        chk("d1_cnt",   32'(br_cnt_o),   32'h1);
        rd(4'b0001);
        chk("d1_fl",    32'(br_recovery_fl_head_o), 32'h3);

        // async reset between edges
        rst = 1'b0; #1;
        chk("async_rst_valid", 32'(br_valid_o), 32'h0);
        chk("async_rst_cnt",   32'(br_cnt_o),   32'h0);
        rst = 1'b1;
        @(posedge clk); #1;

        // chain of three, then recover middle one
        disp(4'b0001, 4'b0000, 5'd1);
        disp(4'b0010, 4'b0001, 5'd2);
        disp(4'b0100, 4'b0011, 5'd4);
        chk("chain_valid", 32'(br_valid_o), 32'h7);
        chk("chain_cnt",   32'(br_cnt_o),   32'h3);
        rob_br_recovery_i = 1'b1;
        rd(4'b0010);
        chk("rec_mask", 32'(br_recovery_mask_o),    32'h1);
        chk("rec_fl",   32'(br_recovery_fl_head_o), 32'h2);
        tick();
        chk("rec_valid", 32'(br_valid_o), 32'h1);
        chk("rec_cnt",   32'(br_cnt_o),   32'h1);

        // rebuild, then correct-predict the oldest
        disp(4'b0010, 4'b0001, 5'd2);
        disp(4'b0100, 4'b0011, 5'd4);
        rob_br_tag_i = 4'b0001;
        rob_br_pred_correct_i = 1'b1;
        tick();
        chk("cor_valid", 32'(br_valid_o), 32'h6);
        rd(4'b0010);
        chk("cor_mask1", 32'(br_recovery_mask_o), 32'h0);
        rd(4'b0100);
        chk("cor_mask2", 32'(br_recovery_mask_o), 32'h2);
        chk("cor_err",   32'(br_err_o), 32'h0);

        // fill, then same-cycle correct + redispatch of tag 0
        disp(4'b0001, 4'b0000, 5'd7);
        disp(4'b1000, 4'b0111, 5'd9);
        chk("fill_full", 32'(br_full_o), 32'h1);
        chk("fill_cnt",  32'(br_cnt_o),  32'h4);
        rob_br_tag_i = 4'b0001;
        rob_br_pred_correct_i = 1'b1;
        disp(4'b0001, 4'b1110, 5'd11);
        chk("fwd_full", 32'(br_full_o), 32'h1);
        chk("fwd_cnt",  32'(br_cnt_o),  32'h4);
        rd(4'b0001);
        chk("fwd_mask0", 32'(br_recovery_mask_o),    32'hE);
        chk("fwd_fl0",   32'(br_recovery_fl_head_o), 32'hB);
        rd(4'b1000);
        chk("fwd_mask3", 32'(br_recovery_mask_o), 32'h6);
        chk("fwd_err",   32'(br_err_o), 32'h0);

        // recovery on 0100 with a competing dispatch: e0 (1110) and e3 (0110) depend on bit 2
        rob_br_tag_i = 4'b0100;
        rob_br_recovery_i = 1'b1;
        disp(4'b0100, 4'b0000, 5'd1);
        chk("recdisp_valid", 32'(br_valid_o), 32'h2);
        chk("recdisp_cnt",   32'(br_cnt_o),   32'h1);
        chk("recdisp_full",  32'(br_full_o),  32'h0);

        // correct-predict an invalid tag
        rob_br_tag_i = 4'b1000;
        rob_br_pred_correct_i = 1'b1;
        tick();
`ifdef BR_STACK_CHECK_EN
        chk("err_set",  32'(br_err_o), 32'h1);
        tick();
        chk("err_hold", 32'(br_err_o), 32'h1);
`else
        chk("err_off",  32'(br_err_o), 32'h0);
        tick();
        chk("err_off2", 32'(br_err_o), 32'h0);
`endif
        rst = 1'b0; #1;
        chk("err_clr", 32'(br_err_o), 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;

        // reset in the middle of a recovery is discarded
        disp(4'b0001, 4'b0000, 5'd5);
        rob_br_tag_i = 4'b0001;
        rob_br_recovery_i = 1'b1;
        #1;
        rst = 1'b0; #1;
        rst = 1'b1;
        rob_br_recovery_i = 1'b0;
        disp(4'b0010, 4'b0000, 5'd6);
        chk("midrec_valid", 32'(br_valid_o), 32'h2);
        chk("midrec_cnt",   32'(br_cnt_o),   32'h1);
        chk("midrec_err",   32'(br_err_o),   32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/br_stack.md
BR_STACK -- requirements
Module: br_stack

Interface
REQ-001 Parameter BR_MASK_W, default 4: number of branch tags and checkpoint entries; tags are one-hot.
REQ-002 Parameter FL_PTR_W, default 5: width of the free-list head pointer checkpointed per branch.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 dispatch_br_en_i  input  1  speculative branch dispatched this cycle; allocate a checkpoint.
REQ-006 dispatch_br_tag_i  input  BR_MASK_W  one-hot tag assigned to the dispatched branch.
REQ-007 dispatch_br_mask_i  input  BR_MASK_W  branch mask in force before this branch; this is the value restored on its misprediction.
REQ-008 fl_head_i  input  FL_PTR_W  free-list head at dispatch.
REQ-009 rob_br_pred_correct_i  input  1  the branch tagged rob_br_tag_i resolved correctly.
REQ-010 rob_br_recovery_i  input  1  the branch tagged rob_br_tag_i mispredicted.
REQ-011 rob_br_tag_i  input  BR_MASK_W  one-hot tag of the resolving branch.
REQ-012 br_recovery_mask_o  output  BR_MASK_W  stored mask of entry rob_br_tag_i (combinational); feeds the mask generator's recovery mask input.
REQ-013 br_recovery_fl_head_o  output  FL_PTR_W  stored free-list head of entry rob_br_tag_i (combinational).
REQ-014 br_valid_o  output  BR_MASK_W  registered per-entry valid vector.
REQ-015 br_cnt_o  output  $clog2(BR_MASK_W)+1  registered count of valid entries.
REQ-016 br_full_o  output  1  all entries valid.
REQ-017 br_err_o  output  1  sticky protocol error flag (see Configuration).

Function
REQ-018 Entry index = bit position of the one-hot tag; each entry holds valid, mask[BR_MASK_W] and fl_head[FL_PTR_W].
REQ-019 Dispatch with no recovery: entry dispatch_br_tag_i <= valid 1, mask dispatch_br_mask_i, fl_head fl_head_i; visible the next cycle.
REQ-020 Correct prediction of tag T: clear valid of entry T, and clear bit T in the mask of every entry, including an entry being written in the same cycle.
REQ-021 Dispatch and correct prediction of the same tag in one cycle (tag forwarding): the write wins; the entry is valid, with bit T cleared from its written mask.
REQ-022 Recovery of tag T: outputs read entry T in the same cycle; on the next edge, clear valid of entry T and of every entry whose stored mask has bit T set.
REQ-023 Recovery takes priority: a dispatch or correct-prediction in the same cycle as recovery is ignored.
REQ-024 Stored masks and fl_head of invalid entries are don't-care, but the outputs for an invalid index shall still be driven deterministically from the stored fields.
REQ-025 br_cnt_o = popcount(br_valid_o); br_full_o = &br_valid_o; both update in the same cycle as the valid vector.
REQ-026 Read latency is zero (combinational index); write and invalidate latency is one cycle.

Reset
REQ-027 Asserting rst low immediately clears all valid bits, masks, fl_heads and br_err_o, and hence br_cnt_o and br_full_o, independent of clk.
REQ-028 Reset mid-recovery discards the recovery; the first edge after deassertion behaves as an empty stack.

Configuration
REQ-029 Macro BR_STACK_CHECK_EN defined: br_err_o sets and holds at 1 until reset if any of these occur:
- a dispatch writes an already-valid entry that is not being freed in the same cycle;
- a correct prediction or recovery targets an invalid entry;
- dispatch_br_tag_i or rob_br_tag_i is not one-hot while its enable is high.
REQ-030 Macro BR_STACK_CHECK_EN undefined: br_err_o is constant 0 and no checker logic is built.

Verification (BR_MASK_W=4, FL_PTR_W=5)
REQ-031 Reset, then dispatch tag 0001 with mask 0000 and fl_head 3 -> next cycle br_valid_o=0001, br_cnt_o=1; with rob_br_tag_i=0001, br_recovery_fl_head_o=3.
REQ-032 Dispatch tags 0001, 0010 (mask 0001), 0100 (mask 0011), then correct 0001 -> entry 0010 mask=0000, entry 0100 mask=0010, br_valid_o=0110.
REQ-033 From the REQ-032 state before the correct, recover 0010 -> same cycle br_recovery_mask_o=0001; next cycle br_valid_o=0001, br_cnt_o=1.
REQ-034 Fill all four entries, then in one cycle correct 0001 and dispatch 0001 with mask 1110 -> br_full_o stays 1, entry 0 mask=1110, br_err_o=0.
REQ-035 Recovery on 0100 with dispatch_br_en_i high in the same cycle -> the dispatch is dropped; entry 0100 and its dependents are invalid next cycle.
REQ-036 With BR_STACK_CHECK_EN defined, correct-predict an invalid tag 1000 -> br_err_o=1 next cycle and held until rst is asserted low.
